// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential three-operand multiplier.
package mult_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_C  = 3'd2,
        MUL_AB  = 3'd3,
        MUL_ABC = 3'd4,
        DONE    = 3'd5
    } mul_state_t;

    localparam logic [1:0] OP_A    = 2'd0;
    localparam logic [1:0] OP_B    = 2'd1;
    localparam logic [1:0] OP_C    = 2'd2;
    localparam logic [1:0] OP_BUSY = 2'd3;

    function automatic int unsigned prod_width(input int unsigned w);
        return 3 * w;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Iterative shift-add multiplier core, reloaded by the controller for each pass.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             step,
    input  logic [prod_width(WIDTH)-1:0]     mcand_in,
    input  logic [WIDTH-1:0]                 mplr_in,
    output logic [prod_width(WIDTH)-1:0]     acc_next_c,
    output logic                             done_c
);

    localparam int unsigned PW = prod_width(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplr;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    // Sum after the current step; done_c flags the step that finishes the pass.
    always_comb begin
        acc_next_c = acc + (mplr[0] ? mcand : PW'(0));
        done_c     = step && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= mcand_in;
            mplr  <= mplr_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_next_c;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_triple_multiplier.sv
// Handshaked A*B*C multiplier: operands arrive serially, two shift-add passes, valid/ready result.
module seq_triple_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic [1:0]             op_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*WIDTH-1:0]     out_product
);

    localparam int unsigned PW = prod_width(WIDTH);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             load_a, load_b, load_c, prod_load;
    logic             in_ready_d, out_valid_d;
    logic [1:0]       op_sel_d;
    logic             accept;
    logic             core_start, core_step, core_done;
    logic [PW-1:0]    core_mcand, core_acc_next;
    logic [WIDTH-1:0] core_mplr;

    assign accept = in_valid && in_ready;

    shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (core_start),
        .step       (core_step),
        .mcand_in   (core_mcand),
        .mplr_in    (core_mplr),
        .acc_next_c (core_acc_next),
        .done_c     (core_done)
    );

    // The last A*B step reloads the core with the finished partial product and C in the same edge.
    always_comb begin
        state_d     = state_q;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_c      = 1'b0;
        prod_load   = 1'b0;
        out_valid_d = out_valid;
        core_start  = 1'b0;
        core_step   = 1'b0;
        core_mcand  = PW'(a_q);
        core_mplr   = b_q;
        case (state_q)
            LOAD_A: if (accept) begin
                load_a  = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: if (accept) begin
                load_b  = 1'b1;
                state_d = LOAD_C;
            end
            LOAD_C: if (accept) begin
                load_c     = 1'b1;
                core_start = 1'b1;
                state_d    = MUL_AB;
            end
            MUL_AB: begin
                core_step = 1'b1;
                if (core_done) begin
                    core_start = 1'b1;
                    core_mcand = core_acc_next;
                    core_mplr  = c_q;
                    state_d    = MUL_ABC;
                end
            end
            MUL_ABC: begin
                core_step = 1'b1;
                if (core_done) begin
                    prod_load   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase

        in_ready_d = 1'b0;
        op_sel_d   = OP_BUSY;
        case (state_d)
            LOAD_A:  begin in_ready_d = 1'b1; op_sel_d = OP_A; end
            LOAD_B:  begin in_ready_d = 1'b1; op_sel_d = OP_B; end
            LOAD_C:  begin in_ready_d = 1'b1; op_sel_d = OP_C; end
            default: begin in_ready_d = 1'b0; op_sel_d = OP_BUSY; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            in_ready    <= 1'b1;
            op_sel      <= OP_A;
            out_valid   <= 1'b0;
            out_product <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            op_sel    <= op_sel_d;
            out_valid <= out_valid_d;
            if (prod_load) out_product <= core_acc_next;
            if (load_a)    a_q <= in_data;
            if (load_b)    b_q <= in_data;
            if (load_c)    c_q <= in_data;
        end
    end

endmodule

// File: tb/tb_seq_triple_multiplier.sv
// Directed scoreboard bench for seq_triple_multiplier (WIDTH=5).
module tb_seq_triple_multiplier;

    localparam int unsigned W  = 5;
    localparam int unsigned PW = 3 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    op_sel;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_product;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] sb[$];

    seq_triple_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .op_sel      (op_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] model(input int a, input int b, input int c);
        return PW'(a * b * c);
    endfunction

    // Present one operand and hold it until accepted.
    task automatic send(input int v, input int exp_sel);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(v);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_for_operand", 64'(in_ready), 64'(1));
        chk("op_sel_load", 64'(op_sel), 64'(exp_sel));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 31));
    endtask

    task automatic send3(input int a, input int b, input int c);
        send(a, 0);
        send(b, 1);
        sb.push_back(model(a, b, c));
        send(c, 2);
    endtask

    // Called right after the C-accept edge; checks latency, product, hold and handshake.
    task automatic wait_result(input int hold);
        int n = 0;
        logic [PW-1:0] expp;
        out_ready = (hold == 0);
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) begin
                chk("op_sel_busy", 64'(op_sel), 64'(3));
                chk("in_ready_busy", 64'(in_ready), 64'(0));
            end
        end while (!out_valid && n < 40);
        chk("latency_edges", 64'(n), 64'(2 * W));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            expp = '0;
        end else begin
            expp = sb.pop_front();
        end
        chk("product", 64'(out_product), 64'(expp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_product", 64'(out_product), 64'(expp));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", 64'(out_valid), 64'(0));
        chk("post_hs_in_ready", 64'(in_ready), 64'(1));
        chk("post_hs_op_sel", 64'(op_sel), 64'(0));
        chk("post_hs_product", 64'(out_product), 64'(expp));
    endtask

    initial begin
        logic       vld[6];
        int         dat[6];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_op_sel", 64'(op_sel), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_product", 64'(out_product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        send3(3, 4, 5);
        wait_result(0);

        send3(31, 31, 31);
        wait_result(0);

        send3(0, 17, 9);
        wait_result(0);

        send3(2, 3, 7);
        wait_result(4);

        // Operands with idle gaps; gap data must be ignored.
        vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dat = '{6, 25, 7, 2, 19, 10};
        sb.push_back(model(6, 2, 10));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = vld[i];
            in_data  = W'(dat[i]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(0);

        // Abort during the second pass.
        send3(5, 5, 5);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_op_sel", 64'(op_sel), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send3(1, 2, 3);
        wait_result(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_triple_multiplier.md
Name: seq_triple_multiplier

Overview:
- Sequential, handshaked counterpart to the combinational three-operand multiplicator.
- Receives operands A, B and C one at a time over a single shared operand bus, in fixed rotating order.
- Computes A*B*C with an iterative shift-add datapath and presents the product on a valid/ready output.
- Sits between an operand producer (e.g. the rotating A/B/C stimulus processes) and a result consumer.

Parameters:
WIDTH, 5, operand width in bits; the product is 3*WIDTH bits wide.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data holds a valid operand.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  operand value, unsigned.
op_sel  output  2  index of the next operand expected: 0=A, 1=B, 2=C, 3=busy or result pending.
out_valid  output  1  out_product holds the completed A*B*C.
out_ready  input  1  consumer accepts the product.
out_product  output  3*WIDTH  unsigned product A*B*C.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (rst_n).
  - On reset assertion: state=LOAD_A, in_ready=1, op_sel=0, out_valid=0, out_product=0; all internal registers and the step counter are cleared.
- FSM states: LOAD_A, LOAD_B, LOAD_C, MUL_AB, MUL_ABC, DONE.
- Operand loading:
  - in_ready=1 only in the LOAD_* states. op_sel=0/1/2 in LOAD_A/B/C and 3 otherwise.
  - An operand is accepted on a rising edge with in_valid && in_ready. The state then advances LOAD_A->LOAD_B->LOAD_C->MUL_AB.
  - in_valid low holds the current LOAD state indefinitely. Gaps between operands are legal.
- MUL_AB:
  - Exactly WIDTH cycles of shift-add.
  - Each cycle: if the multiplier LSB (B) is 1, acc += multiplicand (A); then multiplicand <<= 1 and multiplier >>= 1.
  - Result is 2*WIDTH bits, zero-extended into the 3*WIDTH accumulator.
- MUL_ABC:
  - Exactly WIDTH cycles, with multiplicand = A*B (3*WIDTH bits) and multiplier = C.
  - Same step rule as MUL_AB.
  - No truncation: the maximum (2^WIDTH-1)^3 fits in 3*WIDTH bits.
- Latency:
  - Let edge e0 be the edge on which C is accepted.
  - out_valid is registered high after edge e(2*WIDTH). For WIDTH=5, that is 10 edges after e0.
  - Latency is fixed and independent of operand values; zero operands do not short-circuit.
- DONE:
  - out_valid=1. out_product is stable while out_valid=1 && !out_ready.
  - On the edge with out_valid && out_ready: out_valid=0, state=LOAD_A, and in_ready=1 from the following cycle. There is no same-cycle operand bypass.
  - out_product keeps its last value after the handshake until the next result overwrites it.
- Input protocol:
  - in_data is ignored when in_ready=0.
  - in_valid may be held high through the compute phase without effect.
- Output protocol:
  - out_ready is ignored while out_valid=0.
- Reset mid-operation:
  - rst_n low in any state aborts immediately (asynchronous). Partial operands and products are discarded and the reset values above apply.
  - The first edge after release can accept A if in_valid=1.
- Arithmetic: all unsigned. No overflow flag is needed.

Decomposition:
- Shared package mult_pkg:
  - state enum mul_state_t.
  - op_sel constants OP_A=2'd0, OP_B=2'd1, OP_C=2'd2, OP_BUSY=2'd3.
  - localparam function for product width (3*WIDTH).
- One natural sub-module, shift_add_core:
  - Holds the multiplicand register (3*WIDTH), multiplier register (WIDTH), accumulator and step counter.
  - Controls: start, step; status: done after WIDTH steps.
  - Instantiated once and reused for both passes. The FSM reloads it with A,B and then with A*B,C.

Test Plan:
- Reset, then A=3, B=4, C=5 on consecutive cycles with out_ready=1 -> op_sel steps 0,1,2,3; out_valid high exactly 10 edges after C accepted; out_product=60.
- A=31, B=31, C=31 -> out_product=29791 (15'h745F), no truncation.
- A=0, B=17, C=9 -> out_product=0, same 10-edge latency.
- A=2, B=3, C=7 with out_ready low for 4 cycles after out_valid -> out_valid and out_product=42 held stable; in_ready=0 until the handshake edge, then 1 on the next cycle.
- in_valid toggling 1,0,0,1,0,1 with data 6,x,x,2,x,10 -> operands latched as A=6, B=2, C=10; out_product=120.
- rst_n pulsed low during MUL_ABC of 5*5*5 -> out_valid=0, in_ready=1, op_sel=0 immediately. A following 1,2,3 sequence -> out_product=6.
